// File: rtl/dla_hld_ram_read_stream_pkg.sv
// Shared types and sizing helpers for the hld RAM port-b read streamer.
package dla_hld_ram_read_stream_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2
  } state_t;

  // Smallest output FIFO that can park every read in flight plus the head word.
  function automatic int min_fifo_depth(input int read_latency);
    return read_latency + 1;
  endfunction

endpackage

// File: rtl/dla_hld_ram_read_stream_fifo.sv
// Output FIFO for returned RAM words; storage is flop-based and reset so the head
// (data + last flag) is clean out of reset.
module dla_hld_ram_read_stream_fifo #(
  parameter  int WIDTH = 41,
  parameter  int DEPTH = 4,
  localparam int CW    = $clog2(DEPTH + 1),
  localparam int PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clock,
  input  logic             resetn,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             valid,
  output logic [CW-1:0]    count
);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr, rd_ptr;
  logic             do_push, do_pop;

  function automatic logic [PW-1:0] bump(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign valid   = (count != '0);
  assign head    = mem[rd_ptr];
  assign do_pop  = pop && valid;
  assign do_push = push && ((count != CW'(DEPTH)) || do_pop);

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= bump(wr_ptr);
      end
      if (do_pop) rd_ptr <= bump(rd_ptr);
      if (do_push != do_pop) count <= do_push ? count + CW'(1) : count - CW'(1);
    end
  end

  // The credit scheme upstream must make a push into a full, non-popping FIFO impossible.
  always @(posedge clock)
    if (resetn) assert (!(push && !do_pop && (count == CW'(DEPTH))));

endmodule

// File: rtl/dla_hld_ram_read_stream.sv
// Streaming reader on port b of a stitched hld RAM: a (base, length) command becomes
// one read per cycle; returns land in a credit-managed FIFO and leave as valid/ready.
module dla_hld_ram_read_stream
  import dla_hld_ram_read_stream_pkg::*;
#(
  parameter int ADDR_WIDTH   = 12,
  parameter int DATA_WIDTH   = 40,
  parameter int READ_LATENCY = 2,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                  clock,
  input  logic                  resetn,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [ADDR_WIDTH-1:0] cmd_base_addr,
  input  logic [ADDR_WIDTH:0]   cmd_length,
  output logic [ADDR_WIDTH-1:0] ram_address,
  output logic                  ram_read_enable,
  input  logic [DATA_WIDTH-1:0] ram_readdata,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_last,
  output logic                  busy
);
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int SW = $clog2(READ_LATENCY + FIFO_DEPTH + 2) + 1;

  state_t                state, next_state;
  logic [ADDR_WIDTH-1:0] cur_addr;
  logic [ADDR_WIDTH:0]   remaining;
  logic [READ_LATENCY:0] vld_pipe, last_pipe;
  logic [CW-1:0]         fifo_count;
  logic [SW-1:0]         credits_used;
  logic                  accept, issue, final_issue, pop;

  assign accept = (state == IDLE) && cmd_valid && (cmd_length != '0);
  assign pop    = out_valid && out_ready;

  // Every read is charged from the cycle it is on the RAM bus until it leaves the FIFO;
  // a pop in this cycle hands its credit straight to the next issue.
  assign credits_used = SW'($countones(vld_pipe)) + SW'(fifo_count) - SW'(pop);
  assign issue        = (state == ISSUE) && (credits_used < SW'(FIFO_DEPTH));
  assign final_issue  = issue && (remaining == (ADDR_WIDTH + 1)'(1));

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) state <= IDLE;
    else         state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (accept) next_state = ISSUE;
      ISSUE:   if (final_issue) next_state = DRAIN;
      DRAIN:   if (pop && out_last && (vld_pipe == '0)) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    cmd_ready = (state == IDLE);
    busy      = (state != IDLE);
  end

  // vld_pipe[0] is the registered read strobe; vld_pipe[READ_LATENCY] marks data on ram_readdata.
  assign ram_read_enable = vld_pipe[0];

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      cur_addr    <= '0;
      remaining   <= '0;
      ram_address <= '0;
      vld_pipe    <= '0;
      last_pipe   <= '0;
    end else begin
      if (accept) begin
        cur_addr  <= cmd_base_addr;
        remaining <= cmd_length;
      end else if (issue) begin
        cur_addr  <= cur_addr + ADDR_WIDTH'(1);
        remaining <= remaining - (ADDR_WIDTH + 1)'(1);
      end
      if (issue) ram_address <= cur_addr;
      vld_pipe  <= {vld_pipe[READ_LATENCY-1:0], issue};
      last_pipe <= {last_pipe[READ_LATENCY-1:0], final_issue};
    end
  end

  dla_hld_ram_read_stream_fifo #(
    .WIDTH(DATA_WIDTH + 1),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clock     (clock),
    .resetn    (resetn),
    .push      (vld_pipe[READ_LATENCY]),
    .push_data ({last_pipe[READ_LATENCY], ram_readdata}),
    .pop       (out_ready),
    .head      ({out_last, out_data}),
    .valid     (out_valid),
    .count     (fifo_count)
  );

  always @(posedge clock)
    assert (FIFO_DEPTH >= min_fifo_depth(READ_LATENCY));

endmodule

// File: tb/tb_dla_hld_ram_read_stream.sv
// Bench for dla_hld_ram_read_stream: four instances at different read latencies share one
// command stream; each has its own RAM model, scoreboard and output monitor.
module tb_dla_hld_ram_read_stream;
  localparam int NI = 4;
  localparam int AW = 4;
  localparam int DW = 40;

  function automatic int rl_of(input int i);
    case (i)
      0: return 2;
      1: return 1;
      2: return 3;
      default: return 4;
    endcase
  endfunction

  function automatic int dep_of(input int i);
    return (i == 0) ? 4 : rl_of(i) + 1;
  endfunction

  logic          clock = 1'b0;
  logic          resetn;
  logic          cmd_valid;
  logic [AW-1:0] cmd_base_addr;
  logic [AW:0]   cmd_length;
  logic [NI-1:0] out_ready;
  logic [NI-1:0] cmd_ready_v, busy_v, re_v, ov_v, last_v;
  logic [NI-1:0][AW-1:0] addr_v;
  logic [DW-1:0] ram_mem [1<<AW];
  int   total = 0;
  int   bad = 0;
  int   rdy_mode = 0;
  logic chk_drain = 1'b0;

  logic [NI-1:0] rel [64];
  logic [NI-1:0] ovl [64];
  logic [NI-1:0] crl [64];
  logic [NI-1:0][AW-1:0] adl [64];

  always #5 clock = ~clock;

  for (genvar g = 0; g < NI; g++) begin : g_inst
    localparam int RL  = rl_of(g);
    localparam int DEP = dep_of(g);
    logic [AW-1:0] ram_address;
    logic          ram_read_enable, out_valid, out_last, cmd_ready, busy;
    logic [DW-1:0] ram_readdata, out_data;
    logic [DW-1:0] rd_pipe [1:RL];
    logic [DW:0]   sb [$];
    logic [DW:0]   got_b, exp_b, held_b;
    logic          held = 1'b0;

    dla_hld_ram_read_stream #(
      .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .READ_LATENCY(RL), .FIFO_DEPTH(DEP)
    ) u_dut (
      .clock(clock), .resetn(resetn), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_base_addr(cmd_base_addr), .cmd_length(cmd_length),
      .ram_address(ram_address), .ram_read_enable(ram_read_enable), .ram_readdata(ram_readdata),
      .out_valid(out_valid), .out_ready(out_ready[g]), .out_data(out_data),
      .out_last(out_last), .busy(busy)
    );

    assign cmd_ready_v[g] = cmd_ready;
    assign busy_v[g]      = busy;
    assign re_v[g]        = ram_read_enable;
    assign ov_v[g]        = out_valid;
    assign last_v[g]      = out_last;
    assign addr_v[g]      = ram_address;

    // RAM port b: fixed latency, junk on the bus whenever no read is returning.
    always @(posedge clock) begin
      rd_pipe[1] <= ram_read_enable ? ram_mem[ram_address] : DW'({$urandom, $urandom});
      for (int k = 2; k <= RL; k++) rd_pipe[k] <= rd_pipe[k-1];
    end
    assign ram_readdata = rd_pipe[RL];

    always @(negedge clock)
      if (resetn && cmd_valid && cmd_ready && cmd_length != '0)
        for (int i = 0; i < int'(cmd_length); i++)
          sb.push_back({ram_mem[(int'(cmd_base_addr) + i) % (1 << AW)], i == int'(cmd_length) - 1});

    always @(negedge resetn) sb.delete();

    always @(negedge clock) begin
      if (resetn) begin
        got_b = {out_data, out_last};
        if (held && out_valid) begin
          total++;
          if (got_b !== held_b) begin
            bad++;
            $display("FAIL hold[%0d] got=%h want=%h", g, got_b, held_b);
          end
        end
        if (out_valid && out_ready[g]) begin
          total++;
          if (sb.size() == 0) begin
            bad++;
            $display("FAIL extra_beat[%0d] got=%h want=none", g, got_b);
          end else begin
            exp_b = sb.pop_front();
            if (got_b !== exp_b) begin
              bad++;
              $display("FAIL beat[%0d] got=%h want=%h", g, got_b, exp_b);
            end
          end
        end
        held   = out_valid && !out_ready[g];
        held_b = got_b;
      end else begin
        held = 1'b0;
      end
      if (chk_drain) begin
        total++;
        if (sb.size() != 0) begin
          bad++;
          $display("FAIL drained[%0d] got=%0d left want=0", g, sb.size());
        end
      end
    end
  end

  initial begin
    out_ready = '1;
    forever begin
      @(posedge clock); #1;
      for (int i = 0; i < NI; i++)
        out_ready[i] = (rdy_mode == 0) ? 1'b1 : (rdy_mode == 1) ? 1'b0 : 1'($urandom_range(0, 1));
    end
  end

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", name, got, want);
    end
  endtask

  task automatic set_mode(input int m);
    rdy_mode = m;
    repeat (2) @(posedge clock);
  endtask

  task automatic send(input int base, input int len);
    @(posedge clock); #1;
    cmd_valid = 1'b1;
    cmd_base_addr = AW'(base);
    cmd_length = (AW + 1)'(len);
    @(posedge clock); #1;
    cmd_valid = 1'b0;
  endtask

  task automatic capture(input int n);
    for (int k = 0; k < n; k++) begin
      @(negedge clock);
      rel[k] = re_v; ovl[k] = ov_v; crl[k] = cmd_ready_v; adl[k] = addr_v;
    end
  endtask

  task automatic wait_idle();
    int n = 0;
    do begin
      @(negedge clock);
      n++;
    end while (!((&cmd_ready_v) && busy_v == '0 && ov_v == '0) && n < 2000);
    chk("idle_reached", 64'(n >= 2000), 64'(0));
  endtask

  task automatic drain_check();
    chk_drain = 1'b1;
    @(negedge clock); #1;
    chk_drain = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int first, last, n;
    resetn = 1'b0; cmd_valid = 1'b0; cmd_base_addr = '0; cmd_length = '0;
    for (int i = 0; i < (1 << AW); i++) ram_mem[i] = DW'({$urandom, $urandom});
    repeat (3) @(posedge clock);
    #1;
    chk("rst_cmd_ready", 64'(cmd_ready_v), 64'({NI{1'b1}}));
    chk("rst_busy", 64'(busy_v), 64'(0));
    chk("rst_rd_en", 64'(re_v), 64'(0));
    chk("rst_out_valid", 64'(ov_v), 64'(0));
    chk("rst_out_last", 64'(last_v), 64'(0));
    chk("rst_address", 64'(addr_v), 64'(0));
    @(posedge clock); #1;
    resetn = 1'b1;

    // base 5, length 4, free-flowing output
    wait_idle();
    send(5, 4);
    capture(14);
    chk("basic_rd_en_k0", 64'(rel[0][0]), 64'(0));
    for (int k = 1; k <= 4; k++) begin
      chk($sformatf("basic_rd_en_k%0d", k), 64'(rel[k][0]), 64'(1));
      chk($sformatf("basic_addr_k%0d", k), 64'(adl[k][0]), 64'(4 + k));
    end
    chk("basic_rd_en_k5", 64'(rel[5][0]), 64'(0));
    chk("basic_valid_k3", 64'(ovl[3][0]), 64'(0));
    for (int k = 4; k <= 7; k++) chk($sformatf("basic_valid_k%0d", k), 64'(ovl[k][0]), 64'(1));
    chk("basic_valid_k8", 64'(ovl[8][0]), 64'(0));
    chk("basic_ready_k7", 64'(crl[7][0]), 64'(0));
    chk("basic_ready_k8", 64'(crl[8][0]), 64'(1));
    for (int i = 0; i < NI; i++) begin
      first = -1;
      for (int k = 13; k >= 0; k--) if (ovl[k][i]) first = k;
      chk($sformatf("first_valid[%0d]", i), 64'(first), 64'(2 + rl_of(i)));
    end
    wait_idle();

    // zero-length command is a no-op
    send(5, 0);
    capture(6);
    for (int k = 0; k < 6; k++)
      chk($sformatf("len0_k%0d", k), 64'({rel[k], ovl[k], crl[k]}), 64'({{NI{1'b0}}, {NI{1'b0}}, {NI{1'b1}}}));
    chk("len0_busy", 64'(busy_v), 64'(0));

    // address wraps past the top of the RAM
    wait_idle();
    send(14, 4);
    capture(8);
    for (int k = 1; k <= 4; k++)
      chk($sformatf("wrap_addr_k%0d", k), 64'(adl[k][0]), 64'((13 + k) % 16));
    wait_idle();

    // output stalled from the start: only FIFO_DEPTH reads may go out
    set_mode(1);
    send(0, 16);
    capture(30);
    for (int i = 0; i < NI; i++) begin
      n = 0;
      for (int k = 0; k < 30; k++) n += int'(rel[k][i]);
      chk($sformatf("stall_reads[%0d]", i), 64'(n), 64'(dep_of(i)));
    end
    chk("stall_rd_en_off", 64'(rel[29]), 64'(0));
    set_mode(0);
    wait_idle();
    drain_check();

    // sustained rate on the instance with headroom for a full pipeline
    send(7, 16);
    capture(30);
    first = -1; last = -1; n = 0;
    for (int k = 0; k < 30; k++)
      if (ovl[k][0]) begin
        if (first < 0) first = k;
        last = k;
        n++;
      end
    chk("rate_beats", 64'(n), 64'(16));
    chk("rate_span", 64'(last - first + 1), 64'(16));
    wait_idle();

    // random commands under random backpressure
    set_mode(2);
    repeat (25) begin
      wait_idle();
      send(int'($urandom_range(0, 15)), int'($urandom_range(0, 16)));
    end
    wait_idle();
    drain_check();

    // reset while reads are in flight
    set_mode(0);
    send(3, 16);
    repeat (3) @(posedge clock);
    #1 resetn = 1'b0;
    #1;
    chk("midrst_rd_en", 64'(re_v), 64'(0));
    chk("midrst_valid", 64'(ov_v), 64'(0));
    chk("midrst_busy", 64'(busy_v), 64'(0));
    chk("midrst_ready", 64'(cmd_ready_v), 64'({NI{1'b1}}));
    chk("midrst_addr", 64'(addr_v), 64'(0));
    @(posedge clock); #1;
    resetn = 1'b1;
    send(9, 5);
    wait_idle();
    drain_check();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
